wb_led_sequencer: RTL and testbench

Wishbone master that plays a programmable pattern table into the LED register block (OUT/TOGGLE/CLEAR/SET at offsets 0x0/0x4/0x8/0xC), with a programmable dwell time between steps. It sits between the control logic (SPI/config registers) and the LED register slave, producing blink, chase and status patterns without CPU involvement. It supports loop and one-shot modes, bus-error/timeout fault reporting, and clean stop on disable.

---
 rtl/wb_led_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_wb_led_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_led_sequencer.sv
// Wishbone master that plays a programmable LED pattern table into the LED register slave,
// one write per step with a programmable dwell between steps.
module wb_led_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LED_WIDTH   = 4,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned ACK_TIMEOUT = 16,
  localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    one_shot,
  input  logic [IDX_W-1:0]        last_idx,
  input  logic [CNT_WIDTH-1:0]    dwell,
  input  logic                    pat_we,
  input  logic [IDX_W-1:0]        pat_addr,
  input  logic [LED_WIDTH+1:0]    pat_data,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic                    wbm_we_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_cyc_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  output logic                    busy,
  output logic [IDX_W-1:0]        step_idx,
  output logic                    done,
  output logic                    fault
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0]     TmoLast = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam logic [IDX_W-1:0]     IdxOne  = IDX_W'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StBus, StDwell} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    armed_q, armed_d;
  logic                    fault_q, fault_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
  logic                    stb_q, stb_d;
  logic                    cyc_q, cyc_d;

  logic [LED_WIDTH+1:0]    pat_q [DEPTH];
  logic [LED_WIDTH+1:0]    entry;
  logic [1:0]              entry_op;
  logic [LED_WIDTH-1:0]    entry_leds;

  // Reads the registered table, so a same-cycle write is seen only on the next lap.
  assign entry      = pat_q[idx_q];
  assign entry_op   = entry[LED_WIDTH+1 -: 2];
  assign entry_leds = entry[LED_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i] <= '0;
      end
    end else if (pat_we) begin
      pat_q[pat_addr] <= pat_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    fault_d = fault_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;

    unique case (state_q)
      StIdle: begin
        if (enable && armed_q) begin
          state_d = StFetch;
          fault_d = 1'b0;
          idx_d   = '0;
        end
      end
      StFetch: begin
        if (!enable) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          adr_d        = '0;
          adr_d[3:0]   = {entry_op, 2'b00};
          adr_d        = BASE_ADDR + adr_d;
          dat_d        = '0;
          dat_d[LED_WIDTH-1:0] = entry_leds;
          we_d         = 1'b1;
          sel_d        = '1;
          stb_d        = 1'b1;
          cyc_d        = 1'b1;
          tmo_d        = '0;
          state_d      = StBus;
        end
      end
      StBus: begin
        // Error beats ack; a missing response aborts on the ACK_TIMEOUT-th cycle.
        if (wbm_err_i || (!wbm_ack_i && tmo_q == TmoLast)) begin
          {we_d, stb_d, cyc_d} = 3'b000;
          sel_d   = '0;
          fault_d = 1'b1;
          idx_d   = '0;
          state_d = StIdle;
        end else if (wbm_ack_i) begin
          {we_d, stb_d, cyc_d} = 3'b000;
          sel_d = '0;
          if (!enable) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d   = (dwell == '0) ? CntOne : dwell;
            state_d = StDwell;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StDwell: begin
        if (!enable) begin
          idx_d   = '0;
          state_d = StIdle;
        end else if (cnt_q > CntOne) begin
          cnt_d = cnt_q - CntOne;
        end else if (idx_q == last_idx && one_shot) begin
          done_d  = 1'b1;
          armed_d = 1'b0;
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d   = (idx_q == last_idx) ? '0 : idx_q + IdxOne;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable) begin
      armed_d = 1'b1;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      armed_q <= 1'b1;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      fault_q <= fault_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = cyc_q;
  assign busy      = busy_q;
  assign step_idx  = idx_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_wb_led_sequencer.sv
// Bench for wb_led_sequencer: a Wishbone slave with programmable ack latency/error, plus a
// transaction-level model predicting every write's address, data, start cycle and length.
module tb_wb_led_sequencer;

  localparam int DEPTH       = 8;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        one_shot = 1'b0;
  logic [2:0]  last_idx = '0;
  logic [23:0] dwell = '0;
  logic        pat_we = 1'b0;
  logic [2:0]  pat_addr = '0;
  logic [5:0]  pat_data = '0;
  logic [31:0] adr, dat;
  logic        we, stb, cyc, ack, err, busy, done, fault;
  logic [3:0]  sel;
  logic [2:0]  step_idx;

  always #5 clk = ~clk;

  wb_led_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .one_shot  (one_shot),
    .last_idx  (last_idx),
    .dwell     (dwell),
    .pat_we    (pat_we),
    .pat_addr  (pat_addr),
    .pat_data  (pat_data),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_stb_o (stb),
    .wbm_cyc_o (cyc),
    .wbm_ack_i (ack),
    .wbm_err_i (err),
    .busy      (busy),
    .step_idx  (step_idx),
    .done      (done),
    .fault     (fault)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Slave: responds when stb has been high ack_lat cycles (-1 = never); err replaces the ack
  // of write number err_at.
  int         ack_lat = 0;
  int         err_at = 0;
  int         wait_cnt = 0;
  int         wr_done = 0;
  logic [3:0] led_reg = '0;

  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    if (cyc && stb && wait_cnt == ack_lat) begin
      if (err_at == wr_done + 1) err = 1'b1;
      else ack = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (cyc && stb) begin
      if (ack || err) begin
        wait_cnt <= 0;
        wr_done  <= wr_done + 1;
        if (ack) begin
          case (adr[3:2])
            2'd0:    led_reg <= dat[3:0];
            2'd1:    led_reg <= led_reg ^ dat[3:0];
            2'd2:    led_reg <= led_reg & ~dat[3:0];
            default: led_reg <= led_reg | dat[3:0];
          endcase
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Model: expected writes, derived from the table contents and the step-timing rules.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int          start;
    int          len;
  } wr_t;

  wr_t         exp_q[$];
  logic [5:0]  tbl [DEPTH];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  int          log_cyc[$];
  int          done_cnt = 0;

  task automatic push(input logic [31:0] a, input logic [31:0] d, input int s, input int l);
    wr_t w;
    w.adr = a; w.dat = d; w.start = s; w.len = l;
    exp_q.push_back(w);
  endtask

  task automatic expect_run(input int start, input int n);
    int idx = 0;
    int t = start;
    int len = (ack_lat < 0) ? ACK_TIMEOUT : ack_lat + 1;
    int dw = (dwell == 0) ? 1 : int'(dwell);
    for (int i = 0; i < n; i++) begin
      push({28'd0, tbl[idx][5:4], 2'b00}, {28'd0, tbl[idx][3:0]}, t, len);
      t += 1 + len + dw;
      idx = (idx == int'(last_idx)) ? 0 : (idx + 1) % DEPTH;
    end
  endtask

  logic        cyc_prev = 1'b0;
  int          run_len = 0;
  logic [31:0] adr_hold = '0;
  logic [31:0] dat_hold = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (cyc && !cyc_prev) begin
          log_adr.push_back(adr);
          log_dat.push_back(dat);
          log_cyc.push_back(cyc_cnt);
          check("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            check("wr_start", cyc_cnt, exp_q[0].start);
            check("wr_adr", adr, exp_q[0].adr);
            check("wr_dat", dat, exp_q[0].dat);
          end
          adr_hold = adr;
          dat_hold = dat;
          run_len  = 0;
        end else if (cyc) begin
          check("adr_stable", adr, adr_hold);
          check("dat_stable", dat, dat_hold);
        end
        if (cyc) begin
          run_len++;
          check("stb_with_cyc", stb, 1);
          check("we_with_cyc", we, 1);
          check("sel_with_cyc", sel, 4'hf);
        end else begin
          check("stb_idle", stb, 0);
        end
        if (!cyc && cyc_prev && exp_q.size() > 0) begin
          check("wr_len", run_len, exp_q[0].len);
          exp_q.delete(0);
        end
        cyc_prev = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [1:0] op, input logic [3:0] leds);
    pat_we   = 1'b1;
    pat_addr = a[2:0];
    pat_data = {op, leds};
    tbl[a]   = {op, leds};
    tick(1);
    pat_we   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick(1);
      i++;
    end
    check("idle_in_budget", busy, 0);
  endtask

  task automatic drain(input int n);
    tick(n);
    check("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic clear_logs();
    log_adr.delete();
    log_dat.delete();
    log_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;

    // Reset values
    #12;
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_sel", sel, 0);
    check("rst_adr", adr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_idx", step_idx, 0);
    #8 rst_n = 1'b1;
    tick(2);

    // Loop chase, then disable in DWELL
    load(0, 2'd0, 4'h1); load(1, 2'd0, 4'h2); load(2, 2'd0, 4'h4); load(3, 2'd0, 4'h8);
    last_idx = 3; dwell = 5; one_shot = 0; ack_lat = 1;
    clear_logs();
    k = cyc_cnt;
    enable = 1'b1;
    expect_run(k + 2, 6);
    for (int i = 0; i < 44; i++) begin
      tick(1);
      check("loop_busy", busy, 1);
    end
    check("loop_idx", step_idx, 1);
    enable = 1'b0;
    tick(1);
    check("dwell_stop_busy", busy, 0);
    check("dwell_stop_idx", step_idx, 0);
    drain(12);
    check("loop_count", log_dat.size(), 6);
    check("loop_d0", log_dat[0], 1);
    check("loop_d1", log_dat[1], 2);
    check("loop_d2", log_dat[2], 4);
    check("loop_d3", log_dat[3], 8);
    check("loop_d4", log_dat[4], 1);
    check("loop_a0", log_adr[0], 0);
    check("loop_period", log_cyc[1] - log_cyc[0], 8);

    // One-shot SET/TOGGLE/CLEAR; enable held high afterwards must not restart
    load(0, 2'd3, 4'h3); load(1, 2'd1, 4'h1); load(2, 2'd2, 4'h2);
    last_idx = 2; one_shot = 1; dwell = 2; ack_lat = 0;
    clear_logs();
    done_cnt = 0;
    k = cyc_cnt;
    enable = 1'b1;
    expect_run(k + 2, 3);
    tick(2);
    wait_idle(40);
    drain(20);
    check("ops_done_once", done_cnt, 1);
    check("ops_leds", led_reg, 4'h0);
    check("ops_busy", busy, 0);
    check("ops_fault", fault, 0);
    check("ops_a0", log_adr[0], 32'hC);
    check("ops_a1", log_adr[1], 32'h4);
    check("ops_a2", log_adr[2], 32'h8);

    // Ack timeout
    enable = 1'b0;
    tick(1);
    load(0, 2'd0, 4'h5);
    last_idx = 0; one_shot = 0; dwell = 1; ack_lat = -1;
    k = cyc_cnt;
    enable = 1'b1;
    expect_run(k + 2, 1);
    tick(5);
    enable = 1'b0;
    wait_idle(40);
    check("tmo_fault", fault, 1);
    check("tmo_idx", step_idx, 0);
    drain(5);

    // Bus error on the second write; restart clears fault
    load(0, 2'd0, 4'h1); load(1, 2'd0, 4'h2); load(2, 2'd0, 4'h4);
    last_idx = 2; dwell = 1; ack_lat = 2;
    err_at = wr_done + 2;
    k = cyc_cnt;
    enable = 1'b1;
    expect_run(k + 2, 2);
    tick(1);
    check("fault_cleared", fault, 0);
    tick(7);
    enable = 1'b0;
    wait_idle(40);
    check("err_fault", fault, 1);
    drain(10);
    err_at = 0;

    // Disable mid-BUS with a slow slave: cycle must complete
    ack_lat = 4; dwell = 3;
    k = cyc_cnt;
    enable = 1'b1;
    expect_run(k + 2, 1);
    tick(3);
    enable = 1'b0;
    tick(3);
    check("bus_cyc_held", cyc, 1);
    check("bus_busy_held", busy, 1);
    tick(1);
    check("bus_done_cyc", cyc, 0);
    check("bus_done_busy", busy, 0);
    check("bus_done_idx", step_idx, 0);
    check("bus_fault", fault, 0);
    drain(10);

    // dwell=0 and a table write during FETCH of the same entry
    load(0, 2'd0, 4'h1); load(1, 2'd0, 4'h2);
    last_idx = 1; dwell = 0; ack_lat = 0; one_shot = 0;
    k = cyc_cnt;
    enable = 1'b1;
    push(32'h0, 32'h1, k + 2, 1);
    push(32'h0, 32'h2, k + 5, 1);
    push(32'h0, 32'h9, k + 8, 1);
    push(32'h0, 32'h2, k + 11, 1);
    tick(1);
    pat_we = 1'b1; pat_addr = 3'd0; pat_data = {2'd0, 4'h9}; tbl[0] = {2'd0, 4'h9};
    tick(1);
    pat_we = 1'b0;
    tick(10);
    enable = 1'b0;
    tick(1);
    check("d0_busy", busy, 0);
    drain(10);

    // Reset in the middle of a bus cycle clears the bus and the table
    load(0, 2'd0, 4'h7);
    last_idx = 0; dwell = 2; ack_lat = -1;
    k = cyc_cnt;
    enable = 1'b1;
    expect_run(k + 2, 1);
    tick(3);
    check("pre_rst_cyc", cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cyc", cyc, 0);
    check("async_rst_stb", stb, 0);
    check("async_rst_busy", busy, 0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    one_shot = 1; ack_lat = 0;
    clear_logs();
    k = cyc_cnt;
    enable = 1'b1;
    expect_run(k + 2, 1);
    tick(2);
    wait_idle(20);
    drain(5);
    check("rst_table_writes", log_dat.size(), 1);
    check("rst_fault_after", fault, 0);
    enable = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
